merge_block_to_stream: RTL and testbench
========================================

MERGE_BLOCK_TO_STREAM -- requirements
Module: merge_block_to_stream

Interface
REQ-001 The block SHALL have a parameter MAX_BLK, default 16384, giving the maximum bytes allowed per block.
REQ-002 The block SHALL have the port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have the port i_en, input, 1 bit: input byte valid this cycle; there is no backpressure.
REQ-005 The block SHALL have the port i_eos, input, 1 bit: the current byte is the last byte of the stream.
REQ-006 The block SHALL have the port i_eob, input, 1 bit: the current byte is the last byte of the block.
REQ-007 The block SHALL have the port i_byte, input, 8 bits: the input data byte.
REQ-008 The block SHALL have the port o_en, output, 1 bit: output byte valid.
REQ-009 The block SHALL have the port o_sos, output, 1 bit: the output byte is the first byte of a stream.
REQ-010 The block SHALL have the port o_eos, output, 1 bit: the output byte is the last byte of a stream.
REQ-011 The block SHALL have the port o_byte, output, 8 bits: the output data byte.
REQ-012 The block SHALL have the port o_len, output, 32 bits: total stream length in bytes, valid only when o_eos is 1.
REQ-013 The block SHALL have the port o_nblk, output, 16 bits: block count of the stream, valid only when o_eos is 1.
REQ-014 The block SHALL have the port o_err, output, 1 bit: one-cycle protocol-error pulse.
REQ-015 The block SHALL have the port o_err_code, output, 2 bits: error cause, valid when o_err is 1.

Function
REQ-016 The block SHALL implement a 2-state FSM.
- IDLE: no stream open.
- STRM: stream open.
- IDLE to STRM on an accepted byte with i_eos=0.
- STRM to IDLE on an accepted byte with i_eos=1.
- An accepted byte with i_eos=1 while in IDLE SHALL leave the FSM in IDLE (a single-byte stream).
REQ-017 An accepted byte is a cycle with i_en=1; when i_en=0, i_byte SHALL be ignored.
REQ-018 The output SHALL follow each accepted byte after a fixed 1-cycle latency:
- o_en=1;
- o_byte=i_byte;
- o_eos=i_eos;
- o_sos=1 exactly when the FSM was in IDLE on the accepting cycle.
REQ-019 In cycles with no accepted byte on the previous edge, o_en, o_sos, o_eos, o_byte, o_len and o_nblk SHALL all be 0.
REQ-020 An internal 15-bit block byte counter (bcnt) SHALL hold the number of bytes already accepted in the current block.
- It SHALL be cleared to 0 after any byte that closes the block.
- It SHALL otherwise increment by 1.
REQ-021 A byte SHALL close a block when any of the following holds:
- i_eob=1;
- i_eos=1;
- bcnt == MAX_BLK-1 (forced close).
REQ-022 An internal 16-bit block count SHALL increment, saturating at 0xFFFF, on every block close, and SHALL clear after an i_eos byte.
REQ-023 An internal 32-bit stream length SHALL increment, saturating at 0xFFFFFFFF, on every accepted byte, and SHALL clear after an i_eos byte.
REQ-024 On the o_eos output cycle, o_len SHALL equal the byte count of the stream including the last byte, and o_nblk SHALL equal the block count including the final block.
REQ-025 Error code 2 (eos without eob): a byte with i_eos=1 and i_eob=0 SHALL raise o_err=1, o_err_code=2; the stream SHALL still close normally.
REQ-026 Error code 1 (block overrun): a byte with bcnt == MAX_BLK-1, i_eob=0 and i_eos=0 SHALL raise o_err=1, o_err_code=1 and force a block close.
REQ-027 Error code 3 (stray marker): a cycle with i_en=0 and (i_eos or i_eob)=1 SHALL raise o_err=1, o_err_code=3 one cycle later; the FSM and all counters SHALL be unaffected.
REQ-028 Error priority SHALL be code 2 over code 1; at most one error SHALL be reported per cycle.
REQ-029 Outside an error cycle, o_err_code SHALL be 0.
REQ-030 o_err SHALL be aligned with the o_en cycle of the offending byte (codes 1 and 2).
REQ-031 Back-to-back streams with no idle cycle between them SHALL be supported; the byte after an i_eos byte SHALL produce o_sos=1.

Reset
REQ-032 While rstn=0, all outputs SHALL be 0, the FSM SHALL be IDLE, and bcnt, the block count and the stream length SHALL be 0.
REQ-033 A reset mid-stream SHALL discard the partial stream; the first accepted byte after release SHALL produce o_sos=1 with counts starting from 1.

Verification
REQ-034 Stimulus: 3 bytes 0x11, 0x22, 0x33, with eob=eos=1 on 0x33.
- Required response: o_en for 3 cycles, each 1 cycle after its input.
- o_sos=1 on 0x11.
- o_eos=1, o_len=3 and o_nblk=1 on 0x33.
- o_err=0 throughout.
REQ-035 Stimulus: a 40000-byte stream with eob on bytes 16384 and 32768 and eob+eos on byte 40000.
- Required response: o_len=40000 and o_nblk=3 on the final byte, with no errors.
REQ-036 Stimulus: 16385 bytes with no eob, the last with eos=1 and eob=1.
- Required response: o_err=1 with code 1 on the output of byte 16384.
- Final output: o_len=16385, o_nblk=2.
REQ-037 Stimulus: a single byte with eos=1 and eob=0 while IDLE, followed immediately by a single byte with eos=eob=1.
- Required response: the first byte gives o_sos=o_eos=1, o_err code 2, o_len=1.
- The next byte gives o_sos=1, o_len=1, with no error.
REQ-038 Stimulus: pulse i_eob with i_en=0 in the middle of a stream.
- Required response: o_err code 3 one cycle later.
- The stream's final o_len and o_nblk are unchanged.
REQ-039 Stimulus: assert rstn=0 after 5 bytes, release it, then send 2 bytes with eos+eob on the second.
- Required response: o_sos=1 on the first byte after reset.
- o_len=2 and o_nblk=1 on the second byte.

Source files
------------

// File: rtl/merge_block_to_stream_if.sv
// merge_block_to_stream_if: byte-stream input and merged-stream output bundle
interface merge_block_to_stream_if;
    logic        i_en;
    logic        i_eos;
    logic        i_eob;
    logic [7:0]  i_byte;
    logic        o_en;
    logic        o_sos;
    logic        o_eos;
    logic [7:0]  o_byte;
    logic [31:0] o_len;
    logic [15:0] o_nblk;
    logic        o_err;
    logic [1:0]  o_err_code;
    modport master (
        output i_en, i_eos, i_eob, i_byte,
        input  o_en, o_sos, o_eos, o_byte, o_len, o_nblk, o_err, o_err_code
    );
    modport slave (
        input  i_en, i_eos, i_eob, i_byte,
        output o_en, o_sos, o_eos, o_byte, o_len, o_nblk, o_err, o_err_code
    );
endinterface

// File: rtl/merge_block_to_stream.sv
// merge_block_to_stream: merges blocks into streams, tracking length, block count and protocol errors
module merge_block_to_stream #(
    parameter int MAX_BLK = 16384
) (
    input logic clk,
    input logic rstn,
    merge_block_to_stream_if.slave bus
);
    typedef enum logic {IDLE, STRM} state_t;
    state_t      state_q, state_d;
    logic [14:0] bcnt_q, bcnt_d;
    logic [15:0] nblk_q, nblk_d;
    logic [31:0] len_q, len_d;
    logic        en_q, en_d, sos_q, sos_d, eos_q, eos_d, err_q, err_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] olen_q, olen_d;
    logic [15:0] onblk_q, onblk_d;
    logic [1:0]  code_q, code_d;
    logic        full, close;
    logic [15:0] nblk_inc;
    logic [31:0] len_inc;
    // next-state for FSM/counters and the registered output image of the current byte
    always_comb begin
        full     = bcnt_q == 15'(MAX_BLK - 1);
        close    = bus.i_eob | bus.i_eos | full;
        nblk_inc = (close && nblk_q != '1) ? nblk_q + 16'd1 : nblk_q;
        len_inc  = (len_q != '1) ? len_q + 32'd1 : len_q;
        state_d  = bus.i_en ? (bus.i_eos ? IDLE : STRM) : state_q;
        bcnt_d   = bus.i_en ? (close ? '0 : bcnt_q + 15'd1) : bcnt_q;
        nblk_d   = bus.i_en ? (bus.i_eos ? '0 : nblk_inc) : nblk_q;
        len_d    = bus.i_en ? (bus.i_eos ? '0 : len_inc) : len_q;
        en_d     = bus.i_en;
        sos_d    = bus.i_en & (state_q == IDLE);
        eos_d    = bus.i_en & bus.i_eos;
        byte_d   = bus.i_en ? bus.i_byte : '0;
        olen_d   = bus.i_en ? len_inc : '0;
        onblk_d  = bus.i_en ? nblk_inc : '0;
        code_d   = !bus.i_en ? ((bus.i_eos | bus.i_eob) ? 2'd3 : 2'd0)
                 : (bus.i_eos & !bus.i_eob) ? 2'd2
                 : (full & !bus.i_eob & !bus.i_eos) ? 2'd1 : 2'd0;
        err_d    = code_d != 2'd0;
    end
    // state, counters and one-cycle output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            nblk_q  <= '0;
            len_q   <= '0;
            en_q    <= 1'b0;
            sos_q   <= 1'b0;
            eos_q   <= 1'b0;
            byte_q  <= '0;
            olen_q  <= '0;
            onblk_q <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            nblk_q  <= nblk_d;
            len_q   <= len_d;
            en_q    <= en_d;
            sos_q   <= sos_d;
            eos_q   <= eos_d;
            byte_q  <= byte_d;
            olen_q  <= olen_d;
            onblk_q <= onblk_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end
    assign bus.o_en       = en_q;
    assign bus.o_sos      = sos_q;
    assign bus.o_eos      = eos_q;
    assign bus.o_byte     = byte_q;
    assign bus.o_len      = olen_q;
    assign bus.o_nblk     = onblk_q;
    assign bus.o_err      = err_q;
    assign bus.o_err_code = code_q;
endmodule

// File: tb/tb_merge_block_to_stream.sv
// tb_merge_block_to_stream: directed stimulus checked every cycle against a stream-level model
module tb_merge_block_to_stream;
    localparam int MAX = 16384;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    merge_block_to_stream_if bus ();
    merge_block_to_stream #(.MAX_BLK(MAX)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic        e_en = 0, e_sos = 0, e_eos = 0, e_err = 0;
    logic [7:0]  e_byte = 0;
    logic [31:0] e_len = 0;
    logic [15:0] e_nblk = 0;
    logic [1:0]  e_code = 0;
    bit m_open = 0;
    int m_blk = 0, m_len = 0, m_nblk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // compare DUT outputs against the model expectation each cycle
    always @(negedge clk) begin
        chk("o_en", 32'(bus.o_en), 32'(e_en));
        chk("o_sos", 32'(bus.o_sos), 32'(e_sos));
        chk("o_eos", 32'(bus.o_eos), 32'(e_eos));
        chk("o_byte", 32'(bus.o_byte), 32'(e_byte));
        chk("o_err", 32'(bus.o_err), 32'(e_err));
        chk("o_err_code", 32'(bus.o_err_code), 32'(e_code));
        if (!e_en || e_eos) begin
            chk("o_len", bus.o_len, e_len);
            chk("o_nblk", 32'(bus.o_nblk), 32'(e_nblk));
        end
    end

    task automatic step(input bit en, input bit eos, input bit eob, input logic [7:0] b);
        logic n_en, n_sos, n_eos, n_err;
        logic [7:0] n_byte;
        logic [31:0] n_len;
        logic [15:0] n_nblk;
        logic [1:0] n_code;
        @(negedge clk);
        bus.i_en = en; bus.i_eos = eos; bus.i_eob = eob; bus.i_byte = b;
        n_en = en; n_sos = 0; n_eos = 0; n_byte = 0; n_len = 0; n_nblk = 0; n_err = 0; n_code = 0;
        if (en) begin
            n_sos = !m_open;
            n_eos = eos;
            n_byte = b;
            m_blk++;
            m_len++;
            if (eos && !eob) n_code = 2;
            else if (m_blk == MAX && !eob && !eos) n_code = 1;
            if (eob || eos || m_blk == MAX) begin
                m_nblk++;
                m_blk = 0;
            end
            n_len = 32'(m_len);
            n_nblk = 16'(m_nblk);
            if (eos) begin
                m_open = 0; m_len = 0; m_nblk = 0;
            end else m_open = 1;
        end else if (eos || eob) n_code = 3;
        n_err = n_code != 0;
        @(posedge clk);
        #1;
        e_en = n_en; e_sos = n_sos; e_eos = n_eos; e_byte = n_byte;
        e_len = n_len; e_nblk = n_nblk; e_err = n_err; e_code = n_code;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        bus.i_en = 0; bus.i_eos = 0; bus.i_eob = 0; bus.i_byte = 0;
        @(posedge clk);
        #2;
        rstn = 0;
        m_open = 0; m_blk = 0; m_len = 0; m_nblk = 0;
        e_en = 0; e_sos = 0; e_eos = 0; e_byte = 0; e_len = 0; e_nblk = 0; e_err = 0; e_code = 0;
        #1;
        chk("rst_o_en", 32'(bus.o_en), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1;
    endtask

    initial begin
        bus.i_en = 0; bus.i_eos = 0; bus.i_eob = 0; bus.i_byte = 0;
        repeat (3) @(posedge clk);
        chk("reset_len", bus.o_len, 32'd0);
        #2;
        rstn = 1;
        step(0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h11);
        chk("r34_sos", 32'(bus.o_sos), 32'd1);
        step(1, 0, 0, 8'h22);
        step(1, 1, 1, 8'h33);
        chk("r34_byte", 32'(bus.o_byte), 32'h33);
        chk("r34_len", bus.o_len, 32'd3);
        chk("r34_nblk", 32'(bus.o_nblk), 32'd1);
        step(0, 0, 0, 8'h00);
        step(1, 1, 0, 8'hA5);
        chk("r37_code", 32'(bus.o_err_code), 32'd2);
        chk("r37_len", bus.o_len, 32'd1);
        chk("r37_sos_eos", 32'({bus.o_sos, bus.o_eos}), 32'd3);
        step(1, 1, 1, 8'h5A);
        chk("r37b_sos", 32'(bus.o_sos), 32'd1);
        chk("r37b_err", 32'(bus.o_err), 32'd0);
        step(1, 0, 0, 8'h01);
        step(1, 0, 0, 8'h02);
        step(0, 0, 1, 8'hFF);
        chk("r38_code", 32'(bus.o_err_code), 32'd3);
        step(1, 1, 1, 8'h03);
        chk("r38_len", bus.o_len, 32'd3);
        chk("r38_nblk", 32'(bus.o_nblk), 32'd1);
        step(0, 1, 0, 8'h77);
        chk("stray_idle_code", 32'(bus.o_err_code), 32'd3);
        for (int i = 1; i <= 40000; i++) begin
            step(1, i == 40000, i == 16384 || i == 32768 || i == 40000, 8'(i));
            if (i == 40000) begin
                chk("r35_len", bus.o_len, 32'd40000);
                chk("r35_nblk", 32'(bus.o_nblk), 32'd3);
            end
        end
        step(0, 0, 0, 8'h00);
        for (int i = 1; i <= 16385; i++) begin
            step(1, i == 16385, i == 16385, 8'(i * 3));
            if (i == 16384) chk("r36_code", 32'(bus.o_err_code), 32'd1);
            if (i == 16385) begin
                chk("r36_len", bus.o_len, 32'd16385);
                chk("r36_nblk", 32'(bus.o_nblk), 32'd2);
            end
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h40 + i));
        rst_pulse();
        step(1, 0, 0, 8'hC1);
        chk("r39_sos", 32'(bus.o_sos), 32'd1);
        step(1, 1, 1, 8'hC2);
        chk("r39_len", bus.o_len, 32'd2);
        chk("r39_nblk", 32'(bus.o_nblk), 32'd1);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
